// File: rtl/seq_bit_scanner_if.sv
// Handshake/result bundle for the sequential bit scanner.
// master = requester driving scans, slave = the scanner itself.
interface seq_bit_scanner_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
);
  logic             start;
  logic [WIDTH-1:0] flag_in;
  logic             dir;
  logic             next;
  logic             abort;
  logic             busy;
  logic             hit_valid;
  logic [IDX_W-1:0] hit_idx;
  logic             done;
  logic             found_any;
  logic [IDX_W:0]   hit_count;

  modport master (
    output start, flag_in, dir, next, abort,
    input  busy, hit_valid, hit_idx, done, found_any, hit_count
  );

  modport slave (
    input  start, flag_in, dir, next, abort,
    output busy, hit_valid, hit_idx, done, found_any, hit_count
  );
endinterface

// File: rtl/seq_bit_scanner.sv
// Sequential first-set-bit scanner: tests one flag bit per clock in either
// direction, stops on each set bit until resumed, and pulses done on exhaustion.
module seq_bit_scanner #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  seq_bit_scanner_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HIT  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_UP = IDX_W'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] flag_reg, flag_reg_n;
  logic             dir_reg, dir_reg_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] hit_idx_r, hit_idx_n;
  logic             done_r, done_n;
  logic             found_r, found_n;
  logic [IDX_W:0]   count_r, count_n;

  logic             at_last;
  logic [IDX_W-1:0] ptr_step;

  assign at_last  = dir_reg ? (ptr == '0) : (ptr == LAST_UP);
  assign ptr_step = dir_reg ? (ptr - IDX_W'(1)) : (ptr + IDX_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      flag_reg  <= '0;
      dir_reg   <= 1'b0;
      ptr       <= '0;
      hit_idx_r <= '0;
      done_r    <= 1'b0;
      found_r   <= 1'b0;
      count_r   <= '0;
    end else begin
      state     <= state_n;
      flag_reg  <= flag_reg_n;
      dir_reg   <= dir_reg_n;
      ptr       <= ptr_n;
      hit_idx_r <= hit_idx_n;
      done_r    <= done_n;
      found_r   <= found_n;
      count_r   <= count_n;
    end
  end

  always_comb begin
    state_n    = state;
    flag_reg_n = flag_reg;
    dir_reg_n  = dir_reg;
    ptr_n      = ptr;
    hit_idx_n  = hit_idx_r;
    done_n     = 1'b0;
    found_n    = found_r;
    count_n    = count_r;

    // Abort beats start/next and suppresses done; accumulated results are kept.
    if (bus.abort && (state != IDLE)) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            flag_reg_n = bus.flag_in;
            dir_reg_n  = bus.dir;
            ptr_n      = bus.dir ? LAST_UP : '0;
            found_n    = 1'b0;
            count_n    = '0;
            state_n    = SCAN;
          end
        end
        SCAN: begin
          if (flag_reg[ptr]) begin
            hit_idx_n = ptr;
            count_n   = count_r + (IDX_W+1)'(1);
            found_n   = 1'b1;
            state_n   = HIT;
          end else if (at_last) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            ptr_n = ptr_step;
          end
        end
        HIT: begin
          if (bus.next) begin
            if (at_last) begin
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              ptr_n   = ptr_step;
              state_n = SCAN;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.hit_valid = (state == HIT);
  assign bus.hit_idx   = hit_idx_r;
  assign bus.done      = done_r;
  assign bus.found_any = found_r;
  assign bus.hit_count = count_r;

endmodule

// File: tb/tb_seq_bit_scanner.sv
// Randomised bench for seq_bit_scanner; expectations come from the list of
// set bits in scan order and the edge at which scanning (re)started.
module tb_seq_bit_scanner;
  localparam int W  = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  seq_bit_scanner_if #(.WIDTH(W), .IDX_W(IW)) bus ();

  seq_bit_scanner #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advances one edge, applying abort when that edge is the chosen one.
  task automatic step(input int abort_at, inout int k, output bit ab);
    bus.abort = (k + 1 == abort_at);
    tick();
    k++;
    ab = bus.abort;
    bus.abort = 1'b0;
  endtask

  task automatic check_idle_results(input string tag, input int nh);
    check_val({tag, "_busy"}, 32'(bus.busy), 0);
    check_val({tag, "_hv"},   32'(bus.hit_valid), 0);
    check_val({tag, "_done"}, 32'(bus.done), 0);
    check_val({tag, "_cnt"},  32'(bus.hit_count), 32'(nh));
    check_val({tag, "_any"},  32'(bus.found_any), 32'(nh > 0));
  endtask

  // One complete scan. Scan position q maps to bit q (dir=0) or W-1-q (dir=1).
  // With resume edge r and previous position p, position q is tested at edge r+(q-p);
  // exhaustion is signalled at edge r+(W-1-p).
  task automatic run_scan(input logic [W-1:0] v, input logic d, input int abort_at,
                          input int dmin, input int dmax, input bit noise);
    int hits[$];
    int k, ref_e, prev, nh, ev, dly;
    bit ab;
    for (int q = 0; q < W; q++) begin
      int idx;
      idx = d ? (W - 1 - q) : q;
      if (v[idx]) hits.push_back(q);
    end

    bus.flag_in = v;
    bus.dir     = d;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    k = 0;
    check_val("start_busy", 32'(bus.busy), 1);
    check_val("start_cnt", 32'(bus.hit_count), 0);
    ref_e = 0;
    prev  = -1;
    nh    = 0;

    for (int guard = 0; guard <= W; guard++) begin
      ev = (nh < hits.size()) ? ref_e + hits[nh] - prev : ref_e + (W - 1) - prev;
      while (k < ev) begin
        if (noise) begin
          bus.next    = 1'($urandom);
          bus.start   = 1'($urandom);
          bus.flag_in = W'($urandom);
          bus.dir     = 1'($urandom);
        end
        step(abort_at, k, ab);
        bus.next  = 1'b0;
        bus.start = 1'b0;
        if (ab) begin
          check_idle_results("abort_scan", nh);
          return;
        end
        if (k < ev) begin
          check_val("scan_hv", 32'(bus.hit_valid), 0);
          check_val("scan_done", 32'(bus.done), 0);
          check_val("scan_busy", 32'(bus.busy), 1);
        end
      end

      if (nh < hits.size()) begin
        int exp_idx;
        exp_idx = d ? (W - 1 - hits[nh]) : hits[nh];
        nh++;
        check_val("hit_valid", 32'(bus.hit_valid), 1);
        check_val("hit_idx", 32'(bus.hit_idx), 32'(exp_idx));
        check_val("hit_cnt", 32'(bus.hit_count), 32'(nh));
        check_val("hit_any", 32'(bus.found_any), 1);
        check_val("hit_done", 32'(bus.done), 0);
        dly = $urandom_range(dmax, dmin);
        for (int j = 0; j < dly; j++) begin
          if (noise) bus.start = 1'($urandom);
          step(abort_at, k, ab);
          bus.start = 1'b0;
          if (ab) begin
            check_idle_results("abort_hit", nh);
            return;
          end
          check_val("hold_hv", 32'(bus.hit_valid), 1);
          check_val("hold_idx", 32'(bus.hit_idx), 32'(exp_idx));
        end
        bus.next = 1'b1;
        step(abort_at, k, ab);
        bus.next = 1'b0;
        if (ab) begin
          check_idle_results("abort_next", nh);
          return;
        end
        check_val("resume_hv", 32'(bus.hit_valid), 0);
        ref_e = k;
        prev  = hits[nh-1];
      end else begin
        check_val("done_pulse", 32'(bus.done), 1);
        check_val("done_busy", 32'(bus.busy), 0);
        check_val("done_hv", 32'(bus.hit_valid), 0);
        check_val("done_cnt", 32'(bus.hit_count), 32'(nh));
        check_val("done_any", 32'(bus.found_any), 32'(nh > 0));
        tick();
        check_val("done_clear", 32'(bus.done), 0);
        check_val("idle_busy", 32'(bus.busy), 0);
        return;
      end
    end
    check_val("scan_bound", 1, 0);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.flag_in = '0;
    bus.dir     = 1'b0;
    bus.next    = 1'b0;
    bus.abort   = 1'b0;
    tick();
    tick();
    check_val("rst_busy", 32'(bus.busy), 0);
    check_val("rst_hv", 32'(bus.hit_valid), 0);
    check_val("rst_idx", 32'(bus.hit_idx), 0);
    check_val("rst_done", 32'(bus.done), 0);
    check_val("rst_any", 32'(bus.found_any), 0);
    check_val("rst_cnt", 32'(bus.hit_count), 0);
    rst = 1'b0;
    tick();

    run_scan(16'h2000, 1'b0, 0, 1, 1, 1'b0);
    run_scan(16'h2000, 1'b1, 0, 2, 2, 1'b0);
    run_scan(16'h0000, 1'b0, 0, 0, 0, 1'b0);
    run_scan(16'h8001, 1'b0, 0, 0, 0, 1'b0);
    run_scan(16'hFFFF, 1'b1, 0, 0, 0, 1'b0);
    run_scan(16'h0100, 1'b0, 10, 3, 3, 1'b1);

    // abort while idle must leave held results alone
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_idle_results("idle_abort", 1);

    // synchronous reset in the middle of a scan
    bus.flag_in = 16'h0400;
    bus.dir     = 1'b0;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mid_rst_busy", 32'(bus.busy), 0);
    check_val("mid_rst_hv", 32'(bus.hit_valid), 0);
    check_val("mid_rst_idx", 32'(bus.hit_idx), 0);
    check_val("mid_rst_cnt", 32'(bus.hit_count), 0);
    check_val("mid_rst_any", 32'(bus.found_any), 0);
    run_scan(16'h0004, 1'b0, 0, 1, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] v;
      int sel, ab_at;
      sel = $urandom_range(5, 0);
      case (sel)
        0: v = '0;
        1: v = '1;
        2: v = W'($urandom) & W'($urandom) & W'($urandom);
        default: v = W'($urandom);
      endcase
      ab_at = ($urandom_range(4, 0) == 0) ? $urandom_range(24, 1) : 0;
      run_scan(v, 1'($urandom), ab_at, 0, 3, 1'b1);
      if ($urandom_range(1, 0) == 1) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
